// File: rtl/keypad_pkg.sv
// Shared helpers for the keypad scanner: key numbering and width sizing.
package keypad_pkg;

  // Bit width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int key_index(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: the stable state flips after DEBOUNCE consecutive
// differing samples; rise flags the sampling cycle that accepts a press.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CW = width_of(DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic          stable_reg;
  logic [CW-1:0] cnt_reg;
  logic          flip;

  assign flip = sample_en && (raw != stable_reg) && (cnt_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (sample_en) begin
      if (raw == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == LAST) begin
        stable_reg <= ~stable_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // Combinational so the pending bit is set on the same edge as the stable bit.
  assign rise   = flip && raw;
  assign stable = stable_reg;

endmodule

// File: rtl/matrix_keypad_scanner.sv
// Column-strobed keypad scanner with per-key debounce, a lowest-index-first
// press event arbiter and a debounced LED mirror of the key map.
module matrix_keypad_scanner
  import keypad_pkg::*;
#(
  parameter  int ROWS     = 4,
  parameter  int COLS     = 4,
  parameter  int SCAN_DIV = 1000,
  parameter  int DEBOUNCE = 4,
  localparam int KEYS     = ROWS * COLS,
  localparam int KW       = width_of(KEYS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] rows,
  output logic [COLS-1:0] cols,
  output logic            key_valid,
  output logic [KW-1:0]   key_code,
  output logic            key_held,
  output logic [KEYS-1:0] leds
);

  localparam int DW  = width_of(SCAN_DIV);
  localparam int CLW = width_of(COLS);

  logic [ROWS-1:0] rows_meta_reg;
  logic [ROWS-1:0] rows_sync_reg;
  logic [DW-1:0]   div_reg;
  logic [CLW-1:0]  col_reg;
  logic            sample_en;

  logic [KEYS-1:0] stable;
  logic [KEYS-1:0] rise;
  logic [KEYS-1:0] grant;
  logic [KEYS-1:0] pending_reg;
  logic [KEYS-1:0] pending_next;
  logic            key_valid_reg;
  logic            key_valid_next;
  logic [KW-1:0]   key_code_reg;
  logic [KW-1:0]   key_code_next;

  assign sample_en = (div_reg == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_meta_reg <= '0;
      rows_sync_reg <= '0;
      div_reg       <= '0;
      col_reg       <= '0;
    end else begin
      rows_meta_reg <= rows;
      rows_sync_reg <= rows_meta_reg;
      if (sample_en) begin
        div_reg <= '0;
        col_reg <= (col_reg == CLW'(COLS - 1)) ? '0 : col_reg + 1'b1;
      end else begin
        div_reg <= div_reg + 1'b1;
      end
    end
  end

  assign cols = COLS'(1) << col_reg;

  genvar gi, gj;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      for (gj = 0; gj < COLS; gj++) begin : g_col
        localparam int K = key_index(gi, gj, COLS);
        key_debounce #(
          .DEBOUNCE(DEBOUNCE)
        ) u_deb (
          .clk      (clk),
          .rst      (rst),
          .sample_en(sample_en && (col_reg == CLW'(gj))),
          .raw      (rows_sync_reg[gi]),
          .stable   (stable[K]),
          .rise     (rise[K])
        );
      end
    end
  endgenerate

  // Descending scan leaves the lowest set pending bit as the winner.
  always_comb begin
    key_valid_next = 1'b0;
    key_code_next  = '0;
    grant          = '0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        key_valid_next = 1'b1;
        key_code_next  = KW'(i);
        grant          = '0;
        grant[i]       = 1'b1;
      end
    end
    pending_next = (pending_reg & ~grant) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg   <= '0;
      key_valid_reg <= 1'b0;
      key_code_reg  <= '0;
    end else begin
      pending_reg   <= pending_next;
      key_valid_reg <= key_valid_next;
      key_code_reg  <= key_code_next;
    end
  end

  assign key_valid = key_valid_reg;
  assign key_code  = key_code_reg;
  assign leds      = stable;
  assign key_held  = |stable;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Scoreboard bench: a key-matrix model drives rows from a held key map, a
// sample-level debounce model predicts events, and a monitor checks them.
module tb_matrix_keypad_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SDIV = 8;
  localparam int DEB  = 3;
  localparam int KEYS = ROWS * COLS;
  localparam int SCAN = SDIV * COLS;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ROWS-1:0] rows = '0;
  logic [COLS-1:0] cols;
  logic            key_valid;
  logic [3:0]      key_code;
  logic            key_held;
  logic [KEYS-1:0] leds;

  matrix_keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE(DEB)
  ) dut (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held), .leds(leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int cyc;
  } exp_t;

  exp_t            exp_q[$];
  int              tests = 0;
  int              failed = 0;
  int              cyc = 0;
  int              n = 0;
  int              evt_count = 0;
  logic [KEYS-1:0] keymap = '0;
  logic [KEYS-1:0] stable_m = '0;
  int              cnt_m[KEYS];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Monitor: every presented event must match the oldest predicted one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (key_valid) begin
        evt_count++;
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_event: got code %0d at cycle %0d, expected none", key_code, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_code", 32'(key_code), e.code);
          chk("event_cycle", cyc, e.cyc);
          $display("[TB] event code=%0d cycle=%0d (expected code=%0d cycle=%0d)", key_code, cyc, e.code, e.cyc);
        end
      end
    end
  end

  task automatic set_rows();
    int c;
    c = (n / SDIV) % COLS;
    for (int r = 0; r < ROWS; r++) rows[r] = keymap[r * COLS + c];
  endtask

  task automatic model_clear();
    stable_m = '0;
    for (int k = 0; k < KEYS; k++) cnt_m[k] = 0;
    exp_q.delete();
  endtask

  // One clock; on each column sample apply the debounce rule to that column.
  task automatic step();
    int c;
    int j;
    int k;
    @(posedge clk);
    cyc++;
    n++;
    if (n % SDIV == 0) begin
      c = ((n / SDIV) - 1) % COLS;
      j = 0;
      for (int r = 0; r < ROWS; r++) begin
        k = r * COLS + c;
        if (keymap[k] == stable_m[k]) begin
          cnt_m[k] = 0;
        end else begin
          cnt_m[k]++;
          if (cnt_m[k] == DEB) begin
            stable_m[k] = ~stable_m[k];
            cnt_m[k] = 0;
            if (stable_m[k]) begin
              exp_q.push_back('{k, cyc + 1 + j});
              j++;
            end
          end
        end
      end
    end
    #1;
    chk("cols", 32'(cols), 32'(1) << ((n / SDIV) % COLS));
    chk("leds", 32'(leds), 32'(stable_m));
    chk("key_held", 32'(key_held), 32'(|stable_m));
    set_rows();
  endtask

  task automatic scan(input logic [KEYS-1:0] m);
    keymap = m;
    set_rows();
    repeat (SCAN) step();
  endtask

  // Asynchronous assertion mid-cycle: outputs must clear with no clock edge.
  task automatic do_reset();
    @(posedge clk);
    cyc++;
    #3 rst = 1'b1;
    #1;
    chk("rst_cols", 32'(cols), 32'h1);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_held", 32'(key_held), 32'h0);
    model_clear();
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    set_rows();
  endtask

  initial begin
    int ev0;
    logic [KEYS-1:0] target;
    logic [KEYS-1:0] m;
    model_clear();
    do_reset();

    // Single press of key 11, then held with no further events.
    ev0 = evt_count;
    repeat (5) scan(16'h0800);
    chk("single_leds", 32'(leds), 32'h0800);
    chk("single_held", 32'(key_held), 32'h1);
    chk("single_events", evt_count - ev0, 1);

    // Release produces no event.
    ev0 = evt_count;
    repeat (3) scan(16'h0000);
    chk("release_leds", 32'(leds), 32'h0);
    chk("release_held", 32'(key_held), 32'h0);
    chk("release_events", evt_count - ev0, 0);

    // Bounce on key 5: high 2, low 1, high 3.
    ev0 = evt_count;
    scan(16'h0020); scan(16'h0020); scan(16'h0000);
    chk("bounce_early", evt_count - ev0, 0);
    scan(16'h0020); scan(16'h0020); scan(16'h0020);
    chk("bounce_leds", 32'(leds), 32'h0020);
    chk("bounce_events", evt_count - ev0, 1);
    repeat (3) scan(16'h0000);

    // Keys 1, 9, 13 together in column 1.
    ev0 = evt_count;
    repeat (3) scan(16'h2202);
    chk("simul_leds", 32'(leds), 32'h2202);
    chk("simul_events", evt_count - ev0, 3);
    repeat (3) scan(16'h0000);

    // Reset in the middle of debouncing key 0.
    ev0 = evt_count;
    scan(16'h0001); scan(16'h0001);
    do_reset();
    scan(16'h0001); scan(16'h0001);
    chk("rstdeb_early", evt_count - ev0, 0);
    scan(16'h0001);
    chk("rstdeb_events", evt_count - ev0, 1);
    repeat (3) scan(16'h0000);

    // Random key maps with occasional single-scan glitches.
    target = '0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) target = KEYS'($urandom & $urandom);
      m = target;
      if ($urandom_range(0, 5) == 0) m[$urandom_range(0, KEYS - 1)] ^= 1'b1;
      scan(m);
    end
    repeat (3) scan(16'h0000);
    chk("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/matrix_keypad_scanner.md
# matrix_keypad_scanner

Scans a ROWS x COLS switch matrix by strobing one column at a time and sampling the row inputs. Debounces every key independently and reports each debounced press as a one-cycle event carrying the key index. Mirrors the debounced key map onto an LED vector. It is the parametrised successor of the board's direct row/column-to-LED glue and feeds the game-input logic.

## Interface
- `ROWS`, default 4: number of row inputs (≥1).
- `COLS`, default 4: number of column strobes (≥1).
- `SCAN_DIV`, default 1000: clock cycles spent on each column (≥ROWS+2).
- `DEBOUNCE`, default 4: consecutive identical samples needed to change a key's debounced state (≥1).
- Derived: `KEYS` = ROWS*COLS; `KW` = max(1, clog2(KEYS)).

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rows` in ROWS: raw row lines, active-high, asynchronous to `clk`.
- `cols` out COLS: one-hot active-high column strobe.
- `key_valid` out 1: one-cycle press event.
- `key_code` out KW: index of pressed key, row*COLS+col; valid with `key_valid`.
- `key_held` out 1: high while any debounced key is down.
- `leds` out KEYS: debounced key map, bit row*COLS+col.

## Operation
- `rows` pass through a 2-flop synchronizer before use.
- Divider `div` counts 0..SCAN_DIV-1 and wraps. Column index `col` advances on the wrap: COLS-1 goes to 0. `cols` = one-hot(`col`).
- Sample point: when `div` = SCAN_DIV-1, the synchronized rows are latched as the raw sample for keys (r, `col`), for r = 0..ROWS-1. The column then advances on the same edge.
- Per-key debounce:
  - Each key has a stable bit and a counter of width clog2(DEBOUNCE+1).
  - If a sample equals the stable bit, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE, the stable bit toggles and the counter clears.
  - DEBOUNCE=1 means any change is accepted on the first sample.
- Press event: a stable 0→1 transition sets that key's `pending` bit. Releases (1→0) only update `leds`/`key_held`; they never produce an event.
- Arbiter: each cycle, the lowest-index set `pending` bit is reported via `key_valid`/`key_code` and cleared. One event is issued per cycle.
  - Pending bits can only be set from a single column at a time (at most ROWS per sample), and SCAN_DIV ≥ ROWS+2. The queue therefore always drains before the next sample, and events are never lost.
- `leds` = stable bits. `key_held` = OR of stable bits.

## Timing
- Reset values: `cols` = one-hot bit 0; `div` = 0; `col` = 0; all stable, counter and pending bits = 0; `key_valid` = 0, `key_code` = 0, `key_held` = 0, `leds` = 0.
- `rst` asserted mid-scan clears everything immediately. Any in-flight debounce or pending event is discarded, and no event is issued for keys already held at release of reset until they debounce afresh.
- Row-change → synchronizer: 2 cycles.
- Sample edge T: stable bit / `leds` / `key_held` / `pending` update at T.
  - The first event is registered at T+1: `key_valid`=1 and `key_code` valid for exactly that cycle.
  - k simultaneous presses in one column produce events at T+1..T+k in ascending index order.
- A press held steadily is accepted on its DEBOUNCE-th consecutive sample, one sample per scan period (SCAN_DIV*COLS cycles).
- A bounce, i.e. a differing sample before DEBOUNCE is reached, restarts the count.

## Structure
- Package `keypad_pkg`: `key_index` function (row*COLS+col) and a clog2-based width helper.
- The column divider and the arbiter stay in the top.
- Sub-module `key_debounce` (parameter DEBOUNCE; ports `clk`, `rst`, `sample_en`, `raw`, `stable`, `rise`) is instantiated KEYS times via generate.

## Test plan
All scenarios use ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE=3 (scan period 32 cycles).
- Reset: assert `rst` asynchronously mid-count → `cols`=4'b0001, `leds`=0, `key_valid`=0 with no clock edge. After release, `cols` steps 0001→0010 after 8 cycles and wraps to 0001 after 32 cycles.
- Single press: hold `rows`=4'b0100 only while `cols`=4'b1000 (key 11), stable for 3 scans → one `key_valid` pulse with `key_code`=11, the cycle after the third sample. `leds`[11]=1 and `key_held`=1. No further events while held.
- Bounce: key 5 high for 2 samples, low for 1, then high for 3 → exactly one event (`key_code`=5), issued after the sixth sample.
- Simultaneous: rows 0, 2, 3 high during column 1 → events `key_code`=1, 9, 13 on three consecutive cycles. `leds`=16'h2202.
- Release: release key 11 for 3 samples → `leds`[11]=0 and `key_held`=0, with no `key_valid` pulse.
- Reset during debounce: key 0 seen twice, `rst` pulsed, then key 0 held → the event appears only after 3 post-reset samples.
